// File: rtl/fetcher_icache_if.sv
// rtl/fetcher_icache_if.sv - fetch stage bus: iq request/response, rob flush, byte-wide mc read port
interface fetcher_icache_if;
  logic        is_exception_from_rob;
  logic [31:0] pc_from_iq;
  logic        is_empty_from_iq;
  logic        is_stall_to_iq;
  logic        is_finish_to_iq;
  logic        is_instr_to_iq;
  logic [31:0] instr_to_iq;
  logic        req_to_mc;
  logic        grant_from_mc;
  logic [31:0] addr_to_mc;
  logic [7:0]  data_from_mc;

  modport slave (
    input  is_exception_from_rob, pc_from_iq, is_empty_from_iq, grant_from_mc, data_from_mc,
    output is_stall_to_iq, is_finish_to_iq, is_instr_to_iq, instr_to_iq, req_to_mc, addr_to_mc
  );

  modport master (
    output is_exception_from_rob, pc_from_iq, is_empty_from_iq, grant_from_mc, data_from_mc,
    input  is_stall_to_iq, is_finish_to_iq, is_instr_to_iq, instr_to_iq, req_to_mc, addr_to_mc
  );
endinterface

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped one-word-line icache fetch stage with byte-wide miss fill
module fetcher_icache #(
  parameter int IndexBits = 6
) (
  input logic            clk,
  input logic            rst,
  fetcher_icache_if.slave bus
);
  localparam int Lines   = 1 << IndexBits;
  localparam int TagBits = 32 - IndexBits - 2;

  typedef enum logic [1:0] {IDLE, REQ, READ} state_t;

  state_t               state;
  logic [Lines-1:0]     valid;
  logic [TagBits-1:0]   tags [Lines];
  logic [31:0]          data [Lines];
  logic [31:0]          pc_lat;
  logic [23:0]          fill;
  logic [2:0]           cnt;
  logic [IndexBits-1:0] idx;
  logic [IndexBits-1:0] lat_idx;
  logic [TagBits-1:0]   tag;
  logic                 exc;
  logic                 offer;
  logic                 hit;
  logic                 line_we;

  assign exc     = bus.is_exception_from_rob;
  assign idx     = bus.pc_from_iq[IndexBits+1:2];
  assign tag     = bus.pc_from_iq[31:IndexBits+2];
  assign lat_idx = pc_lat[IndexBits+1:2];
  assign offer   = (state == IDLE) && !bus.is_empty_from_iq && !exc;
  assign hit     = valid[idx] && (tags[idx] == tag);
  assign line_we = rst && !exc && (state == READ) && (cnt == 3'd4);

  // Stall also covers an offer during a flush so the iq keeps the PC.
  assign bus.is_stall_to_iq = (state != IDLE) ||
                              (!bus.is_empty_from_iq && (exc || !hit));
  assign bus.is_instr_to_iq = bus.is_finish_to_iq;

  always_ff @(posedge clk) begin
    if (line_we) begin
      data[lat_idx] <= {bus.data_from_mc, fill};
      tags[lat_idx] <= pc_lat[31:IndexBits+2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      valid               <= '0;
      cnt                 <= '0;
      pc_lat              <= '0;
      fill                <= '0;
      bus.is_finish_to_iq <= 1'b0;
      bus.instr_to_iq     <= '0;
      bus.req_to_mc       <= 1'b0;
      bus.addr_to_mc      <= '0;
    end else begin
      bus.is_finish_to_iq <= 1'b0;
      if (exc) begin
        state         <= IDLE;
        cnt           <= '0;
        bus.req_to_mc <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (offer) begin
              if (hit) begin
                bus.is_finish_to_iq <= 1'b1;
                bus.instr_to_iq     <= data[idx];
              end else begin
                pc_lat        <= {bus.pc_from_iq[31:2], 2'b00};
                state         <= REQ;
                bus.req_to_mc <= 1'b1;
              end
            end
          end
          REQ: begin
            if (bus.grant_from_mc) begin
              state          <= READ;
              cnt            <= '0;
              bus.addr_to_mc <= pc_lat;
            end
          end
          READ: begin
            // Byte n arrives one cycle after address n, i.e. while cnt == n+1.
            case (cnt)
              3'd1:    fill[7:0]   <= bus.data_from_mc;
              3'd2:    fill[15:8]  <= bus.data_from_mc;
              3'd3:    fill[23:16] <= bus.data_from_mc;
              default: ;
            endcase
            if (cnt < 3'd3) begin
              bus.addr_to_mc <= pc_lat + {29'd0, cnt} + 32'd1;
            end
            if (cnt == 3'd4) begin
              valid[lat_idx] <= 1'b1;
              bus.req_to_mc  <= 1'b0;
              state          <= IDLE;
              cnt            <= '0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetcher_icache.sv
// tb/tb_fetcher_icache.sv - scoreboard bench for fetcher_icache with a byte-wide memory model
module tb_fetcher_icache;
  logic clk = 1'b0;
  logic rst;

  fetcher_icache_if bus();

  fetcher_icache #(.IndexBits(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          req_rises = 0;
  int          last_fin = -10;
  int          prev_fin = -20;
  logic        req_prev = 1'b0;
  logic [31:0] last_instr = '0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] pend_addr = '0;
  int          rcnt = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h00;
      32'h1003: return 8'h00;
      default:  return a[7:0] + 8'h40;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    logic [31:0] b;
    b = {pc[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory controller: grant two cycles after req rises, byte returned one cycle after its address.
  initial forever begin
    @(negedge clk);
    pend_addr = bus.addr_to_mc;
    @(posedge clk);
    #1;
    bus.data_from_mc = mem_byte(pend_addr);
    if (!bus.req_to_mc) begin
      bus.grant_from_mc = 1'b0;
      rcnt = 0;
    end else if (!bus.grant_from_mc) begin
      rcnt++;
      if (rcnt == 3) bus.grant_from_mc = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst === 1'b1 && bus.req_to_mc === 1'b1 && !req_prev) req_rises++;
    req_prev = (bus.req_to_mc === 1'b1);
    if (bus.req_to_mc === 1'b1 && bus.grant_from_mc === 1'b1) addr_log.push_back(bus.addr_to_mc);
    if (bus.is_finish_to_iq === 1'b1) begin
      check("is_instr", {31'd0, bus.is_instr_to_iq}, 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_finish: got instr 0x%08h, expected no response", bus.instr_to_iq);
      end else begin
        e = exp_q.pop_front();
        check("instr", bus.instr_to_iq, e);
      end
      last_instr = bus.instr_to_iq;
      prev_fin   = last_fin;
      last_fin   = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers pc until accepted; called and returns at posedge+1.
  task automatic fetch(input logic [31:0] pc, output int stalls);
    int  n = 0;
    bit  done = 0;
    bus.pc_from_iq       = pc;
    bus.is_empty_from_iq = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (bus.is_stall_to_iq === 1'b0) begin
        exp_q.push_back(word_of(pc));
        done = 1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.is_empty_from_iq = 1'b1;
    if (!done) check("fetch_timeout", 32'(n), 32'd0);
    stalls = n;
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req_to_mc === 1'b1 && bus.addr_to_mc === a) && n < 100);
    if (n >= 100) check(name, bus.addr_to_mc, a);
  endtask

  initial begin
    int s;
    int r0;
    rst = 1'b0;
    bus.is_exception_from_rob = 1'b0;
    bus.pc_from_iq            = '0;
    bus.is_empty_from_iq      = 1'b1;
    bus.grant_from_mc         = 1'b0;
    bus.data_from_mc          = '0;
    step(3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_finish", {31'd0, bus.is_finish_to_iq}, 32'd0);
    check("rst_instr", bus.instr_to_iq, 32'd0);
    check("rst_req", {31'd0, bus.req_to_mc}, 32'd0);
    check("rst_addr", bus.addr_to_mc, 32'd0);
    check("rst_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
    step(1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", {29'd0, bus.is_stall_to_iq, bus.is_finish_to_iq, bus.req_to_mc}, 32'd0);
      step(1);
    end

    addr_log.delete();
    fetch(32'h1000, s);
    check("cold_stalls", 32'(s), 32'd9);
    step(1);
    check("cold_instr", last_instr, 32'h0000_0513);
    check("cold_log_len", 32'(addr_log.size()), 32'd6);
    for (int i = 0; i < 4; i++) check("cold_addr", addr_log[i+1], 32'h1000 + 32'(i));
    check("cold_req_done", {31'd0, bus.req_to_mc}, 32'd0);

    fetch(32'h1004, s);
    check("fill2_stalls", 32'(s), 32'd9);
    step(2);
    fetch(32'h1000, s);
    check("hit_a_stalls", 32'(s), 32'd0);
    fetch(32'h1004, s);
    check("hit_b_stalls", 32'(s), 32'd0);
    step(1);
    check("hit_back2back", 32'(last_fin - prev_fin), 32'd1);
    check("hit_b_instr", last_instr, 32'h4746_4544);

    fetch(32'h1100, s);
    check("conflict_stalls", 32'(s), 32'd9);
    step(1);
    check("conflict_instr", last_instr, 32'h4342_4140);
    r0 = req_rises;
    fetch(32'h1000, s);
    check("conflict_remiss", 32'(s), 32'd9);
    check("conflict_req_rise", 32'(req_rises - r0), 32'd1);
    step(2);

    bus.pc_from_iq            = 32'h1000;
    bus.is_empty_from_iq      = 1'b0;
    bus.is_exception_from_rob = 1'b1;
    @(negedge clk);
    check("exc_hit_stall", {31'd0, bus.is_stall_to_iq}, 32'd1);
    step(1);
    bus.is_exception_from_rob = 1'b0;
    bus.is_empty_from_iq      = 1'b1;
    @(negedge clk);
    check("exc_hit_nofinish", {31'd0, bus.is_finish_to_iq}, 32'd0);
    step(1);

    bus.pc_from_iq       = 32'h3008;
    bus.is_empty_from_iq = 1'b0;
    wait_addr(32'h300A, "flush_wait");
    bus.is_exception_from_rob = 1'b1;
    step(1);
    bus.is_exception_from_rob = 1'b0;
    bus.is_empty_from_iq      = 1'b1;
    @(negedge clk);
    check("flush_req", {31'd0, bus.req_to_mc}, 32'd0);
    check("flush_nofinish", {31'd0, bus.is_finish_to_iq}, 32'd0);
    step(2);
    fetch(32'h2000, s);
    check("post_flush_miss", 32'(s), 32'd9);
    fetch(32'h3008, s);
    check("flush_line_invalid", 32'(s), 32'd9);
    fetch(32'h1000, s);
    fetch(32'h1000, s);
    check("prereset_hit", 32'(s), 32'd0);
    step(2);

    bus.pc_from_iq       = 32'h400C;
    bus.is_empty_from_iq = 1'b0;
    wait_addr(32'h400D, "reset_wait");
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    bus.is_empty_from_iq = 1'b1;
    @(negedge clk);
    check("rr_finish", {31'd0, bus.is_finish_to_iq}, 32'd0);
    check("rr_instr", bus.instr_to_iq, 32'd0);
    check("rr_req", {31'd0, bus.req_to_mc}, 32'd0);
    check("rr_addr", bus.addr_to_mc, 32'd0);
    check("rr_stall", {31'd0, bus.is_stall_to_iq}, 32'd0);
    step(1);
    fetch(32'h1000, s);
    check("rr_remiss", 32'(s), 32'd9);
    step(2);
    check("rr_instr_after", last_instr, 32'h0000_0513);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
